// File: rtl/dmem_dump_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_dump_ctrl
//
// Post-run readout controller that sits between the CPU data port and the
// single-port data memory. While the program runs, the CPU owns the memory
// address and write-enable. When the CPU stores the halt signature, the
// controller raises a sticky done flag. It then takes over the address port
// and walks a fixed window of words, one word per beat. The words are either
// streamed over a valid/ready handshake or stepped by a debounced button.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   cpu_addr      CPU data byte address
//   cpu_wdata     CPU store data
//   cpu_wena      CPU store enable
//   mem_rdata     asynchronous read data from dmem
//   mode          0 = auto stream (valid/ready), 1 = manual step
//   step_pulse    single-cycle advance pulse (manual mode)
//   dump_ready    consumer accepts the current word (auto mode)
//   restart       single-cycle pulse: restart the dump from word 0
//   mem_addr      address driven to dmem
//   mem_wena      gated write enable driven to dmem
//   done          halt signature seen (sticky until reset)
//   busy          dump in progress
//   dump_valid    dump_data holds a valid word
//   dump_data     current dumped word
//   dump_index    index of the current word inside the window
//   dump_last     current word is the final word of the window
// ----------------------------------------------------------------------------
module dmem_dump_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [DATA_W-1:0] HALT_SIG   = 32'ha0602880,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = 32'h100104ac,
    parameter int                DUMP_WORDS = 16,
    parameter int                PTR_W      = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wena,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mode,
    input  logic              step_pulse,
    input  logic              dump_ready,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wena,
    output logic              done,
    output logic              busy,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic [PTR_W-1:0]  dump_index,
    output logic              dump_last
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DUMP = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DUMP_WORDS - 1);
    // In FIN the address stays parked on the final word of the window.
    localparam logic [ADDR_W-1:0] FIN_ADDR = DUMP_BASE + ADDR_W'(4 * (DUMP_WORDS - 1));

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              done_q, done_d;

    logic              halt_hit;
    logic              ptr_is_last;
    logic [PTR_W-1:0]  ptr_wrap_inc;

    // The halt signature only counts when the store is actually enabled.
    assign halt_hit    = cpu_wena && (cpu_wdata == HALT_SIG);
    assign ptr_is_last = (ptr_q == LAST_PTR);
    // Manual stepping wraps explicitly, so non-power-of-two windows also work.
    assign ptr_wrap_inc = ptr_is_last ? '0 : ptr_q + 1'b1;

    // State, pointer and done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. restart is checked before any advance, so it wins
    // over a handshake or a step pulse that arrives in the same cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = done_q;

        unique case (state_q)
            ST_RUN: begin
                if (halt_hit) begin
                    done_d  = 1'b1;
                    ptr_d   = '0;
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (restart) begin
                    ptr_d = '0;
                end else if (mode) begin
                    if (step_pulse) begin
                        ptr_d = ptr_wrap_inc;
                    end
                end else if (dump_ready) begin
                    // Keep the pointer on the last word when the window ends.
                    if (ptr_is_last) begin
                        state_d = ST_FIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                if (restart) begin
                    ptr_d   = '0;
                    state_d = ST_DUMP;
                end
            end
            default: begin
                state_d = ST_RUN;
                ptr_d   = '0;
            end
        endcase
    end

    // Output decode. In RUN the CPU owns the memory port. During the dump the
    // memory read path goes straight to dump_data, so the word appears in the
    // same cycle as its address.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wena   = cpu_wena;
        busy       = 1'b0;
        dump_valid = 1'b0;
        dump_data  = '0;
        dump_index = ptr_q;
        dump_last  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                mem_addr = cpu_addr;
                mem_wena = cpu_wena;
            end
            ST_DUMP: begin
                mem_addr   = DUMP_BASE + (ADDR_W'(ptr_q) << 2);
                mem_wena   = 1'b0;
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_data  = mem_rdata;
                dump_last  = ptr_is_last;
            end
            ST_FIN: begin
                mem_addr = FIN_ADDR;
                mem_wena = 1'b0;
            end
            default: begin
                mem_addr = cpu_addr;
                mem_wena = cpu_wena;
            end
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_dump_ctrl
//
// Directed bench for dmem_dump_ctrl with the default parameters. A small
// word-addressed memory model stands in for dmem. It has an asynchronous
// read and is written on the rising edge. Hand-written sequences cover reset,
// halt detection and the store gating. A table of per-cycle vectors covers
// the auto stream, FIN, restart and step mode. An asynchronous reset in the
// middle of the dump closes the run.
// ----------------------------------------------------------------------------
module tb_dmem_dump_ctrl;

    localparam logic [31:0] HALT     = 32'ha0602880;
    localparam logic [31:0] BASE     = 32'h100104ac;
    localparam logic [31:0] FIN_ADDR = 32'h100104e8;
    localparam logic [31:0] STORE1   = 32'h12345678;
    localparam int          BASE_IDX = 43;   // word index of BASE inside the model

    typedef struct {
        logic mode;
        logic stepPulse;
        logic dumpReady;
        logic restart;
        int   expIndex;
        logic expValid;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wena;
    logic [31:0] mem_rdata;
    logic        mode;
    logic        step_pulse;
    logic        dump_ready;
    logic        restart;
    logic [31:0] mem_addr;
    logic        mem_wena;
    logic        done;
    logic        busy;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic [3:0]  dump_index;
    logic        dump_last;

    logic [31:0] mem [256];
    vec_t        vecs[$];
    int          vecCount = 0;
    int          errCount = 0;

    dmem_dump_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wena   (cpu_wena),
        .mem_rdata  (mem_rdata),
        .mode       (mode),
        .step_pulse (step_pulse),
        .dump_ready (dump_ready),
        .restart    (restart),
        .mem_addr   (mem_addr),
        .mem_wena   (mem_wena),
        .done       (done),
        .busy       (busy),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_index (dump_index),
        .dump_last  (dump_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: asynchronous read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wena) mem[mem_addr[9:2]] <= cpu_wdata;
    end

    // Expected content of window word k after the two program stores.
    function automatic logic [31:0] expWord(int k);
        if (k == 0) return HALT;
        if (k == 1) return STORE1;
        return 32'hd0000000 + 32'(BASE_IDX + k);
    endfunction

    function automatic void addVec(logic m, logic s, logic r, logic rs, int idx, logic v);
        vec_t e;
        e.mode      = m;
        e.stepPulse = s;
        e.dumpReady = r;
        e.restart   = rs;
        e.expIndex  = idx;
        e.expValid  = v;
        vecs.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        @(negedge clk);
        mode       = v.mode;
        step_pulse = v.stepPulse;
        dump_ready = v.dumpReady;
        restart    = v.restart;
        #1;
        checkOutput($sformatf("v%0d busy", n), {31'd0, busy}, {31'd0, v.expValid});
        checkOutput($sformatf("v%0d valid", n), {31'd0, dump_valid}, {31'd0, v.expValid});
        checkOutput($sformatf("v%0d wena", n), {31'd0, mem_wena}, 32'd0);
        checkOutput($sformatf("v%0d done", n), {31'd0, done}, 32'd1);
        if (v.expValid) begin
            checkOutput($sformatf("v%0d index", n), {28'd0, dump_index}, 32'(v.expIndex));
            checkOutput($sformatf("v%0d addr", n), mem_addr, BASE + 32'(4 * v.expIndex));
            checkOutput($sformatf("v%0d data", n), dump_data, expWord(v.expIndex));
            checkOutput($sformatf("v%0d last", n), {31'd0, dump_last}, {31'd0, v.expIndex == 15});
        end else begin
            checkOutput($sformatf("v%0d finaddr", n), mem_addr, FIN_ADDR);
            checkOutput($sformatf("v%0d findata", n), dump_data, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hd0000000 + 32'(i);

        // Auto stream: ready pattern 1,0,0,1 then continuously high.
        addVec(0, 0, 1, 0, 0, 1);
        addVec(0, 0, 0, 0, 1, 1);
        addVec(0, 0, 0, 0, 1, 1);
        addVec(0, 0, 1, 0, 1, 1);
        for (int k = 2; k <= 15; k++) addVec(0, 0, 1, 0, k, 1);
        // FIN: restart together with a step pulse.
        addVec(1, 1, 0, 1, 0, 0);
        // Step mode: 17 pulses, wrapping 15 -> 0, then ready is ignored.
        for (int k = 0; k <= 15; k++) addVec(1, 1, 0, 0, k, 1);
        addVec(1, 1, 0, 0, 0, 1);
        addVec(1, 0, 1, 0, 1, 1);
        // Restart beats a simultaneous auto handshake.
        addVec(0, 0, 1, 1, 1, 1);
        addVec(0, 0, 1, 0, 0, 1);
        addVec(1, 1, 0, 0, 1, 1);
        addVec(1, 1, 0, 0, 2, 1);
        addVec(1, 1, 0, 0, 3, 1);
        addVec(1, 1, 0, 0, 4, 1);
        // Back to auto with ready low: the step pulse has no effect.
        addVec(0, 1, 0, 0, 5, 1);
        addVec(0, 0, 0, 0, 5, 1);

        // Reset state and CPU pass-through.
        rst        = 1'b1;
        cpu_addr   = 32'h11112220;
        cpu_wdata  = 32'h0;
        cpu_wena   = 1'b0;
        mode       = 1'b0;
        step_pulse = 1'b0;
        dump_ready = 1'b0;
        restart    = 1'b0;
        #3;
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst busy", {31'd0, busy}, 32'd0);
        checkOutput("rst valid", {31'd0, dump_valid}, 32'd0);
        checkOutput("rst data", dump_data, 32'd0);
        checkOutput("rst index", {28'd0, dump_index}, 32'd0);
        checkOutput("rst last", {31'd0, dump_last}, 32'd0);
        checkOutput("rst addr", mem_addr, 32'h11112220);
        checkOutput("rst wena", {31'd0, mem_wena}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Halt value without store enable must be ignored.
        @(negedge clk);
        cpu_addr  = BASE;
        cpu_wdata = HALT;
        cpu_wena  = 1'b0;
        #1;
        checkOutput("nowena addr", mem_addr, BASE);
        @(negedge clk);
        checkOutput("nowena done", {31'd0, done}, 32'd0);
        checkOutput("nowena busy", {31'd0, busy}, 32'd0);

        // First program store, then the halt store. Both reach memory.
        cpu_addr  = BASE + 32'd4;
        cpu_wdata = STORE1;
        cpu_wena  = 1'b1;
        #1;
        checkOutput("store1 wena", {31'd0, mem_wena}, 32'd1);
        @(negedge clk);
        cpu_addr  = BASE;
        cpu_wdata = HALT;
        #1;
        checkOutput("store1 mem", mem[BASE_IDX + 1], STORE1);
        checkOutput("halt wena", {31'd0, mem_wena}, 32'd1);
        checkOutput("halt done early", {31'd0, done}, 32'd0);

        // One cycle later: done, dump at word 0, CPU store blocked.
        @(negedge clk);
        cpu_wdata = 32'hdeadbeef;
        #1;
        checkOutput("dump done", {31'd0, done}, 32'd1);
        checkOutput("dump busy", {31'd0, busy}, 32'd1);
        checkOutput("dump valid", {31'd0, dump_valid}, 32'd1);
        checkOutput("dump addr", mem_addr, BASE);
        checkOutput("dump data", dump_data, HALT);
        checkOutput("dump wena", {31'd0, mem_wena}, 32'd0);
        @(negedge clk);
        cpu_addr  = BASE + 32'd4;
        cpu_wdata = HALT;
        #1;
        checkOutput("blocked mem", mem[BASE_IDX], HALT);
        checkOutput("stall index", {28'd0, dump_index}, 32'd0);

        // Table-driven part. The CPU keeps storing the halt value throughout.
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Asynchronous reset in the middle of a cycle at index 5.
        @(posedge clk);
        #2;
        checkOutput("prerst index", {28'd0, dump_index}, 32'd5);
        cpu_wena = 1'b0;
        cpu_addr = 32'h00000040;
        rst      = 1'b1;
        #1;
        checkOutput("arst busy", {31'd0, busy}, 32'd0);
        checkOutput("arst done", {31'd0, done}, 32'd0);
        checkOutput("arst valid", {31'd0, dump_valid}, 32'd0);
        checkOutput("arst addr", mem_addr, 32'h00000040);
        checkOutput("arst index", {28'd0, dump_index}, 32'd0);

        // Restart while running is ignored.
        @(negedge clk);
        rst     = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        #1;
        checkOutput("runrestart busy", {31'd0, busy}, 32'd0);
        checkOutput("runrestart done", {31'd0, done}, 32'd0);
        checkOutput("runrestart addr", mem_addr, 32'h00000040);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
